// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator (1024x768@60 defaults) with registered, zero-skew strobes.
// Optional 16-bit frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_TOTAL     = 1344,
  parameter int HBLANK_STOP = 1344,
  parameter int V_TOTAL     = 806,
  parameter int VBLANK_STOP = 806,
  parameter int H_BLNK_S    = 1024,
  parameter int H_SYNC_S    = 1048,
  parameter int H_SYNC_E    = 1184,
  parameter int V_BLNK_S    = 768,
  parameter int V_SYNC_S    = 771,
  parameter int V_SYNC_E    = 777
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hblnk,
  output logic        hsync,
  output logic        vblnk,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BS     = 11'(H_BLNK_S);
  localparam logic [10:0] H_BE     = 11'(HBLANK_STOP);
  localparam logic [10:0] H_SS     = 11'(H_SYNC_S);
  localparam logic [10:0] H_SE     = 11'(H_SYNC_E);
  localparam logic [10:0] V_BS     = 11'(V_BLNK_S);
  localparam logic [10:0] V_BE     = 11'(VBLANK_STOP);
  localparam logic [10:0] V_SS     = 11'(V_SYNC_S);
  localparam logic [10:0] V_SE     = 11'(V_SYNC_E);

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_next;
  logic [10:0] v_next;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_next = h_wrap ? 11'd0 : hcount + 11'd1;
    v_next = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? 11'd0 : vcount + 11'd1;
    end
  end

  // Strobes decode the next-state counters so they land in the same cycle as the counts they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b0;
      hsync       <= 1'b0;
      vblnk       <= 1'b0;
      vsync       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= (h_next >= H_BS) && (h_next < H_BE);
      hsync       <= (h_next >= H_SS) && (h_next < H_SE);
      vblnk       <= (v_next >= V_BS) && (v_next < V_BE);
      vsync       <= (v_next >= V_SS) && (v_next < V_SE);
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'd0;
    end else if (en && h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a full-size instance and a shrunken-raster instance share stimulus
// and are compared every cycle against an arithmetic raster model (enabled-edge count -> position).
module tb_vga_timing_gen;

  localparam int D_HT = 1344, D_VT = 806;
  localparam int S_HT = 64, S_VT = 20;
  localparam int S_HBS = 40, S_HSS = 44, S_HSE = 52;
  localparam int S_VBS = 12, S_VSS = 14, S_VSE = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;

  logic [10:0] d_hcount, d_vcount, s_hcount, s_vcount;
  logic d_hblnk, d_hsync, d_vblnk, d_vsync, d_line_start, d_frame_start;
  logic s_hblnk, s_hsync, s_vblnk, s_vsync, s_line_start, s_frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_frame_cnt, s_frame_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  longint t_en = 0;
  bit pulse_ok = 1'b0;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic hb, hs, vb, vs, ls, fs;
    logic [15:0] fc;
  } exp_t;

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount(d_hcount), .vcount(d_vcount),
    .hblnk(d_hblnk), .hsync(d_hsync), .vblnk(d_vblnk), .vsync(d_vsync),
    .line_start(d_line_start), .frame_start(d_frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_frame_cnt)
`endif
  );

  vga_timing_gen #(
    .H_TOTAL(S_HT), .HBLANK_STOP(S_HT), .V_TOTAL(S_VT), .VBLANK_STOP(S_VT),
    .H_BLNK_S(S_HBS), .H_SYNC_S(S_HSS), .H_SYNC_E(S_HSE),
    .V_BLNK_S(S_VBS), .V_SYNC_S(S_VSS), .V_SYNC_E(S_VSE)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount(s_hcount), .vcount(s_vcount),
    .hblnk(s_hblnk), .hsync(s_hsync), .vblnk(s_vblnk), .vsync(s_vsync),
    .line_start(s_line_start), .frame_start(s_frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_frame_cnt)
`endif
  );

  // Raster position follows directly from how many enabled edges have elapsed since reset.
  function automatic exp_t model(longint t, bit pulse, int ht, int vt, int hbs, int hss, int hse,
                                 int vbs, int vss, int vse);
    exp_t e;
    longint line;
    int h, v;
    h    = int'(t % ht);
    line = t / ht;
    v    = int'(line % vt);
    e.h  = 11'(h);
    e.v  = 11'(v);
    e.hb = (h >= hbs);
    e.hs = (h >= hss) && (h < hse);
    e.vb = (v >= vbs);
    e.vs = (v >= vss) && (v < vse);
    e.ls = pulse && (h == 0);
    e.fs = pulse && (h == 0) && (v == 0);
    e.fc = 16'((line / vt) % 65536);
    return e;
  endfunction

  task automatic checkField(input string tag, input int obs, input int expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, expv, t_en);
    end
  endtask

  task automatic checkOutput();
    exp_t ed, es;
    ed = model(t_en, pulse_ok, D_HT, D_VT, 1024, 1048, 1184, 768, 771, 777);
    es = model(t_en, pulse_ok, S_HT, S_VT, S_HBS, S_HSS, S_HSE, S_VBS, S_VSS, S_VSE);
    checkField("d_hcount", int'(d_hcount), int'(ed.h));
    checkField("d_vcount", int'(d_vcount), int'(ed.v));
    checkField("d_hblnk", int'(d_hblnk), int'(ed.hb));
    checkField("d_hsync", int'(d_hsync), int'(ed.hs));
    checkField("d_vblnk", int'(d_vblnk), int'(ed.vb));
    checkField("d_vsync", int'(d_vsync), int'(ed.vs));
    checkField("d_line_start", int'(d_line_start), int'(ed.ls));
    checkField("d_frame_start", int'(d_frame_start), int'(ed.fs));
    checkField("s_hcount", int'(s_hcount), int'(es.h));
    checkField("s_vcount", int'(s_vcount), int'(es.v));
    checkField("s_hblnk", int'(s_hblnk), int'(es.hb));
    checkField("s_hsync", int'(s_hsync), int'(es.hs));
    checkField("s_vblnk", int'(s_vblnk), int'(es.vb));
    checkField("s_vsync", int'(s_vsync), int'(es.vs));
    checkField("s_line_start", int'(s_line_start), int'(es.ls));
    checkField("s_frame_start", int'(s_frame_start), int'(es.fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
    checkField("d_frame_cnt", int'(d_frame_cnt), int'(ed.fc));
    checkField("s_frame_cnt", int'(s_frame_cnt), int'(es.fc));
`endif
  endtask

  // Called at a falling edge: drive en, clock once, update the model, check at the next falling edge.
  task automatic applyStimulus(input logic en_val);
    en = en_val;
    @(posedge clk);
    if (rst_n && en_val) begin
      t_en++;
      pulse_ok = 1'b1;
    end else begin
      pulse_ok = 1'b0;
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int n, hs_cnt, hb_cnt, vs_cnt;
    bit found;

    // Reset held for five cycles with en high.
    rst_n = 1'b0;
    en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1);

    // Release; first enabled edge must give hcount=1 and no line_start.
    rst_n = 1'b1;
    applyStimulus(1'b1);
    checkField("first_edge_hcount", int'(d_hcount), 1);

    // Random enable gaps across several shrunken frames.
    for (int i = 0; i < 3000; i++) applyStimulus(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0);

    // Freeze at the last column of the full-size raster.
    found = 1'b0;
    for (int i = 0; i < 1400 && !found; i++) begin
      if ((t_en % D_HT) == D_HT - 1) found = 1'b1;
      else applyStimulus(1'b1);
    end
    checkField("reach_d_h1343", int'(found), 1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0);
    applyStimulus(1'b1);

    // Reach a shrunken-frame wrap, then freeze on (0,0).
    found = 1'b0;
    for (int i = 0; i < 1400 && !found; i++) begin
      applyStimulus(1'b1);
      if (s_frame_start === 1'b1) found = 1'b1;
    end
    checkField("reach_s_frame_wrap", int'(found), 1);
    checkField("wrap_line_start", int'(s_line_start), 1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0);

    // Frame period and vsync width measured from DUT pulses.
    n = 0;
    vs_cnt = 0;
    do begin
      applyStimulus(1'b1);
      n++;
      if (s_vsync === 1'b1) vs_cnt++;
    end while (s_frame_start !== 1'b1 && n < 3000);
    checkField("s_frame_period", n, S_HT * S_VT);
    checkField("s_vsync_cycles", vs_cnt, (S_VSE - S_VSS) * S_HT);

    // One full-size line: hsync and hblnk widths.
    hs_cnt = 0;
    hb_cnt = 0;
    for (int i = 0; i < D_HT; i++) begin
      applyStimulus(1'b1);
      if (d_hsync === 1'b1) hs_cnt++;
      if (d_hblnk === 1'b1) hb_cnt++;
    end
    checkField("d_hsync_cycles", hs_cnt, 136);
    checkField("d_hblnk_cycles", hb_cnt, 320);

    // Asynchronous reset between edges at hcount=600.
    found = 1'b0;
    for (int i = 0; i < 1400 && !found; i++) begin
      if ((t_en % D_HT) == 600) found = 1'b1;
      else applyStimulus(1'b1);
    end
    checkField("reach_d_h600", int'(found), 1);
    #2;
    rst_n = 1'b0;
    t_en = 0;
    pulse_ok = 1'b0;
    #1;
    checkOutput();
    @(negedge clk);
    applyStimulus(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) applyStimulus(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
